vga_line_fetch: RTL and testbench

VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

---
 rtl/vga_line_fetch_pkg.sv | 20 ++
 rtl/vga_line_fetch_if.sv | 14 +
 rtl/vga_line_fetch_ram.sv | 24 ++
 rtl/vga_line_fetch.sv | 119 +++++++++++
 tb/tb_vga_line_fetch.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_line_fetch_pkg.sv
// vga_pkg: raster constants, fetch FSM states and line-buffer indexing shared by the line fetcher
package vga_pkg;
    localparam int H_TOTAL        = 800;
    localparam int V_TOTAL        = 525;
    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int WORDS_PER_LINE = 160;
    localparam int PIX_PER_WORD   = 4;

    typedef enum logic [1:0] {IDLE, REQ, DONE} fetch_state_t;

    function automatic logic [16:0] line_base(input logic [8:0] line);
        return 17'(line) * 17'(WORDS_PER_LINE);
    endfunction

    // Banks are packed back to back, so bank 1 starts right after the 160 words of bank 0.
    function automatic logic [8:0] ram_index(input logic bank, input logic [7:0] word);
        return 9'(word) + (bank ? 9'(WORDS_PER_LINE) : 9'd0);
    endfunction
endpackage

// File: rtl/vga_line_fetch_if.sv
// vga_line_fetch_if: framebuffer read port between the line fetcher and memory
//   mem_req    fetcher -> memory  read request
//   mem_addr   fetcher -> memory  17-bit word address
//   mem_ack    memory -> fetcher  request accepted, mem_rdata valid this cycle
//   mem_rdata  memory -> fetcher  four 3-bit RGB pixels
interface vga_line_fetch_if;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic [11:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/vga_line_fetch_ram.sv
// vga_line_ram: 320x12 simple dual-port line buffer, one write port and one synchronous read port
//   clk             write and read clock
//   we, wbank, wword, wdata   write enable, bank, word and data
//   rbank, rword    read bank and word
//   rdata           read data, one cycle after the read address
module vga_line_ram
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic        wbank,
    input  logic [7:0]  wword,
    input  logic [11:0] wdata,
    input  logic        rbank,
    input  logic [7:0]  rword,
    output logic [11:0] rdata
);
    logic [11:0] mem [0:2*WORDS_PER_LINE-1];

    always_ff @(posedge clk) begin
        if (we) mem[ram_index(wbank, wword)] <= wdata;
        rdata <= mem[ram_index(rbank, rword)];
    end
endmodule

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: prefetches the next VGA line into a ping-pong line buffer and streams its pixels
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   hcnt, vcnt      raster position from the timing stage
//   mem (master)    framebuffer read port: mem_req/mem_addr out, mem_ack/mem_rdata in
//   r, g, b         pixel colour, one cycle behind hcnt/vcnt
//   underrun        sticky missed-deadline flag, cleared by underrun_clr
// Optional: define VGA_FETCH_UNDERRUN_EN for per-bank valid bits and the underrun flag.
module vga_line_fetch
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       hcnt,
    input  logic [9:0]       vcnt,
    vga_line_fetch_if.master mem,
    output logic             r,
    output logic             g,
    output logic             b,
    output logic             underrun,
    input  logic             underrun_clr
);
    fetch_state_t state;
    logic        bank, trig, line_end, ack, last, active, show, blank;
    logic [8:0]  target;
    logic [7:0]  word, rword;
    logic [1:0]  pix;
    logic [11:0] q;

    assign trig     = hcnt == 10'd0 && (vcnt < 10'(V_ACTIVE - 1) || vcnt == 10'(V_TOTAL));
    assign target   = vcnt == 10'(V_TOTAL) ? 9'd0 : 9'(vcnt + 10'd1);
    assign line_end = hcnt == 10'(H_TOTAL);
    assign ack      = state == REQ && mem.mem_ack;
    assign last     = word == 8'(WORDS_PER_LINE - 1);
    assign active   = hcnt < 10'(H_ACTIVE) && vcnt < 10'(V_ACTIVE);
    // Park the read address off-screen so it never leaves the 160-word bank.
    assign rword    = active ? hcnt[9:2] : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bank         <= 1'b0;
            word         <= 8'd0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= 17'd0;
        end else begin
            case (state)
                IDLE: if (trig) begin
                    state        <= REQ;
                    bank         <= target[0];
                    word         <= 8'd0;
                    mem.mem_req  <= 1'b1;
                    mem.mem_addr <= line_base(target);
                end
                // The line deadline beats a pending ack: the fetch is abandoned.
                REQ: if (line_end) begin
                    state       <= IDLE;
                    mem.mem_req <= 1'b0;
                end else if (mem.mem_ack) begin
                    if (last) begin
                        state       <= DONE;
                        mem.mem_req <= 1'b0;
                    end else begin
                        word         <= word + 8'd1;
                        mem.mem_addr <= mem.mem_addr + 17'd1;
                    end
                end
                DONE: if (line_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VGA_FETCH_UNDERRUN_EN
    logic [1:0] valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 2'b00;
            underrun <= 1'b0;
        end else begin
            if (state == IDLE && trig) valid[target[0]] <= 1'b0;
            if (ack && last && !line_end) valid[bank] <= 1'b1;
            underrun <= (state == REQ && line_end) ? 1'b1 : underrun_clr ? 1'b0 : underrun;
        end
    end

    assign show = valid[vcnt[0]];
`else
    logic unused_clr;

    assign unused_clr = underrun_clr;
    assign show       = 1'b1;
    assign underrun   = 1'b0;
`endif

    vga_line_ram u_ram (
        .clk   (clk),
        .we    (ack),
        .wbank (bank),
        .wword (word),
        .wdata (mem.mem_rdata),
        .rbank (vcnt[0]),
        .rword (rword),
        .rdata (q)
    );

    // The RAM output register is the pixel pipeline stage; pixel select and blanking ride alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix   <= 2'd0;
            blank <= 1'b1;
        end else begin
            pix   <= hcnt[1:0];
            blank <= !(active && show);
        end
    end

    assign {r, g, b} = blank ? 3'b000 : 3'(q >> (4'(pix) * 4'd3));
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: directed self-checking bench for vga_line_fetch with a scripted framebuffer
`timescale 1ns/1ps
module tb_vga_line_fetch;
`ifdef VGA_FETCH_UNDERRUN_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] hcnt = 10'd0;
    logic [9:0] vcnt = 10'd0;
    logic       r, g, b, underrun;
    logic       underrun_clr = 1'b0;

    vga_line_fetch_if bus();

    vga_line_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .mem          (bus),
        .r            (r),
        .g            (g),
        .b            (b),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] bank_m  [2][160];
    bit          known_m [2][160];
    bit          valid_m [2];
    bit          und_m;
    logic [2:0]  order   [4] = '{3'b100, 3'b101, 3'b110, 3'b111};

    // Word 0 of every line is 111_110_101_100 so the pixel order is visible at hcnt 0..3.
    function automatic logic [11:0] pat(input int a);
        if (a % 160 == 0) return 12'hFAC;
        return 12'(a * 7 + 3);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One raster line at vcnt=v. The memory acks every period-th requested cycle; underrun_clr pulses at
    // hcnt==clr_at; rst_n drops mid-cycle at hcnt==rst_h (line ends there); exp_last is the last hcnt with
    // mem_req high (-1: no fetch).
    task automatic run_line(input int v, input int period, input int clr_at, input int exp_last,
                            input int rst_h, input string tag);
        int base, acks, reqc, last_req, tgt, w, k;
        bit fetch, bk, db, blk;
        logic [11:0] wd;
        logic [2:0]  exp_rgb;
        vcnt     = 10'(v);
        fetch    = (v < 479) || (v == 525);
        tgt      = (v == 525) ? 0 : v + 1;
        bk       = tgt[0];
        db       = vcnt[0];
        base     = tgt * 160;
        acks     = 0;
        reqc     = 0;
        last_req = -1;
        for (int h = 0; h <= 800; h++) begin
            hcnt          = 10'(h);
            underrun_clr  = (h == clr_at);
            bus.mem_ack   = bus.mem_req && (reqc % period == period - 1);
            bus.mem_rdata = bus.mem_ack ? pat(base + acks) : 12'h000;
            if (h == rst_h) begin
                bus.mem_ack = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                valid_m = '{1'b0, 1'b0};
                und_m   = 1'b0;
                checks++;
                if (bus.mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s async mem_req: got %b want 0", tag, bus.mem_req);
                end
                checks++;
                if ({bus.mem_addr, r, g, b, underrun} !== 21'd0) begin
                    errors++;
                    $display("FAIL %s reset outputs: addr %0d rgb %b%b%b und %b want all 0", tag, bus.mem_addr, r, g, b, underrun);
                end
                break;
            end
            if (h == 0 && fetch) valid_m[bk] = 1'b0;
            if (bus.mem_req) begin
                last_req = h;
                reqc++;
                if (bus.mem_ack) begin
                    checks++;
                    if (bus.mem_addr !== 17'(base + acks)) begin
                        errors++;
                        $display("FAIL %s addr ack %0d: got %0d want %0d", tag, acks, bus.mem_addr, base + acks);
                    end
                    bank_m[bk][acks]  = pat(base + acks);
                    known_m[bk][acks] = 1'b1;
                    acks++;
                    if (acks == 160) valid_m[bk] = 1'b1;
                end
            end
            tick();
            if (h == 800 && fetch && acks < 160) und_m = EN;
            else if (h == clr_at) und_m = 1'b0;
            checks++;
            if (underrun !== und_m) begin
                errors++;
                $display("FAIL %s underrun h=%0d: got %b want %b", tag, h, underrun, und_m);
            end
            w   = h / 4;
            k   = h % 4;
            blk = (h >= 640) || (v >= 480) || (EN && !valid_m[db]);
            if (blk) begin
                checks++;
                if ({r, g, b} !== 3'b000) begin
                    errors++;
                    $display("FAIL %s blank pix h=%0d: got %b%b%b want 000", tag, h, r, g, b);
                end
            end else if (known_m[db][w]) begin
                wd      = bank_m[db][w];
                exp_rgb = (h < 4) ? order[h] : {wd[3*k+2], wd[3*k+1], wd[3*k]};
                checks++;
                if ({r, g, b} !== exp_rgb) begin
                    errors++;
                    $display("FAIL %s pix h=%0d: got %b%b%b want %b", tag, h, r, g, b, exp_rgb);
                end
            end
        end
        underrun_clr = 1'b0;
        bus.mem_ack  = 1'b0;
        if (rst_h < 0) begin
            checks++;
            if (last_req !== exp_last) begin
                errors++;
                $display("FAIL %s last req hcnt: got %0d want %0d", tag, last_req, exp_last);
            end
            checks++;
            if (bus.mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s mem_req after line: got %b want 0", tag, bus.mem_req);
            end
        end
    endtask

    task automatic test_reset;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 12'h000;
        valid_m       = '{1'b0, 1'b0};
        und_m         = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 17'd0) begin
            errors++;
            $display("FAIL reset mem: req %b addr %0d want 0 0", bus.mem_req, bus.mem_addr);
        end
        checks++;
        if ({r, g, b, underrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset pix: rgb %b%b%b und %b want 0000", r, g, b, underrun);
        end
        hcnt  = 10'd5;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset release req: got %b want 0", bus.mem_req);
        end
    endtask

    task automatic test_fetch_full;
        run_line(0, 1, -1, 160, -1, "line0");
        run_line(4, 1, -1, 160, -1, "fetch5");
        run_line(5, 1, -1, 160, -1, "show5");
    endtask

    task automatic test_underrun;
        run_line(6, 6, -1, 800, -1, "abort7");
        run_line(7, 1, -1, 160, -1, "show7");
    endtask

    task automatic test_underrun_clr;
        run_line(8, 6, 800, 800, -1, "clr_abort");
        run_line(9, 1, 300, 160, -1, "clr_alone");
    endtask

    task automatic test_boundary;
        run_line(478, 1, -1, 160, -1, "fetch479");
        run_line(479, 1, -1, -1, -1, "nofetch479");
        run_line(500, 1, -1, -1, -1, "nofetch500");
        run_line(524, 1, -1, -1, -1, "nofetch524");
        run_line(525, 1, -1, 160, -1, "wrap525");
        run_line(0, 1, -1, 160, -1, "show0");
    endtask

    task automatic test_async_reset;
        run_line(1, 6, -1, 0, 50, "rst_mid");
        tick();
        hcnt  = 10'd100;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid release req: got %b want 0", bus.mem_req);
        end
        run_line(2, 1, -1, 160, -1, "show2");
    endtask

    initial begin
        test_reset();
        test_fetch_full();
        test_underrun();
        test_underrun_clr();
        test_boundary();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
